// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clock_meter_pkg;

  // Counter width shared with the clock divider.
  localparam int unsigned DEFAULT_CNT_W = 28;

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_MEASURE    = 2'd1,
    S_STALLED    = 2'd2
  } meter_state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchronizer for an asynchronous input plus a history flop,
// producing single-cycle rise and fall pulses in the local clock domain.
// Edge pulses are suppressed until the pipeline has refilled after reset, so
// an input that is already high at reset release does not look like a rise.
module edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic synced,
  output logic rise,
  output logic fall
);

  localparam int unsigned FILL_MAX = STAGES + 1;
  localparam int unsigned FILL_W   = $clog2(FILL_MAX + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(FILL_MAX);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  logic [STAGES-1:0] sync_ff;
  logic              prev;
  logic [FILL_W-1:0] fill;
  logic              armed;

  // Synchronizer chain and history flop.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_ff <= '0;
      prev    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], async_in};
      prev    <= sync_ff[STAGES-1];
    end
  end

  // Count cycles since reset until every stage and the history flop hold real data.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      fill <= '0;
    end else if (fill != FILL_DONE) begin
      fill <= fill + FILL_ONE;
    end else begin
      fill <= fill;
    end
  end

  assign armed  = (fill == FILL_DONE);
  assign synced = sync_ff[STAGES-1];
  assign rise   = armed & synced & ~prev;
  assign fall   = armed & ~synced & prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// clock_in cycles, with lock detection and stall (timeout) reporting.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned        CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0]   TIMEOUT     = 28'd100_000_000,
  parameter int unsigned        SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid_out,
  output logic             locked_out,
  output logic             timeout_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_reg;
  logic             have_prior;

  meter_state_t     state;
  meter_state_t     state_next;

  // Decoded FSM actions for the registered output stage.
  logic             capture;
  logic             stall_enter;
  logic             restart;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (signal_in),
    .synced   (),
    .rise     (rise),
    .fall     (fall)
  );

  // Cycle counter: restarts at 1 on every rise, saturates at all-ones, idle before the first rise.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if ((state != S_WAIT_FIRST) && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

  // Latch the elapsed count at each falling edge as the high time of the current period.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      high_reg <= '0;
    end else if (fall) begin
      high_reg <= cnt;
    end else begin
      high_reg <= high_reg;
    end
  end

  // FSM state register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= S_WAIT_FIRST;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a rise always takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT_FIRST: begin
        if (rise) begin
          state_next = S_MEASURE;
        end else begin
          state_next = S_WAIT_FIRST;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          state_next = S_MEASURE;
        end else if (cnt == TIMEOUT) begin
          state_next = S_STALLED;
        end else begin
          state_next = S_MEASURE;
        end
      end
      S_STALLED: begin
        if (rise) begin
          state_next = S_MEASURE;
        end else begin
          state_next = S_STALLED;
        end
      end
      default: begin
        state_next = S_WAIT_FIRST;
      end
    endcase
  end

  // FSM output decode: which update the registered outputs perform this cycle.
  always_comb begin
    capture     = 1'b0;
    stall_enter = 1'b0;
    restart     = 1'b0;
    case (state)
      S_WAIT_FIRST: begin
        if (rise) begin
          restart = 1'b1;
        end else begin
          restart = 1'b0;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          capture = 1'b1;
        end else if (cnt == TIMEOUT) begin
          stall_enter = 1'b1;
        end else begin
          capture = 1'b0;
        end
      end
      S_STALLED: begin
        if (rise) begin
          restart = 1'b1;
        end else begin
          restart = 1'b0;
        end
      end
      default: begin
        capture = 1'b0;
      end
    endcase
  end

  // Registered measurement results, lock history and timeout status.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      period_out  <= '0;
      high_out    <= '0;
      valid_out   <= 1'b0;
      locked_out  <= 1'b0;
      timeout_out <= 1'b0;
      have_prior  <= 1'b0;
    end else begin
      valid_out <= capture;
      if (capture) begin
        period_out <= cnt;
        high_out   <= high_reg;
        // period_out still holds the previous measurement here.
        locked_out <= have_prior && (cnt == period_out);
        have_prior <= 1'b1;
      end else if (stall_enter) begin
        timeout_out <= 1'b1;
        locked_out  <= 1'b0;
      end else if (restart) begin
        // First period after (re)start is unknown, so lock history starts over.
        timeout_out <= 1'b0;
        locked_out  <= 1'b0;
        have_prior  <= 1'b0;
      end else begin
        period_out <= period_out;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed scoreboard bench for clock_period_meter (TIMEOUT shortened to 20).
module tb_clock_period_meter;

  localparam int CNT_W = 28;

  logic             clk;
  logic             reset;
  logic             signal_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid_out;
  logic             locked_out;
  logic             timeout_out;

  typedef struct {
    int period;
    int high;
    bit locked;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   watch_to = 1'b0;
  bit   saw_to   = 1'b0;

  clock_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (28'd20),
    .SYNC_STAGES (2)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .signal_in   (signal_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .valid_out   (valid_out),
    .locked_out  (locked_out),
    .timeout_out (timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One period of the measured wave: h cycles high then l cycles low.
  // If has_exp, the rise at the start of this wave completes a measurement.
  task automatic wave(input int h, input int l, input bit has_exp,
                      input int ep, input int eh, input bit el);
    exp_t e;
    if (has_exp) begin
      e.period = ep;
      e.high   = eh;
      e.locked = el;
      exp_q.push_back(e);
    end
    signal_in = 1'b1;
    repeat (h) @(negedge clk);
    signal_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid: got period=%0d high=%0d locked=%0d, expected no valid",
                 period_out, high_out, locked_out);
      end else begin
        e = exp_q.pop_front();
        if (period_out == CNT_W'(e.period) && high_out == CNT_W'(e.high) && locked_out == e.locked) begin
          n_pass++;
        end else begin
          $display("FAIL measurement: got period=%0d high=%0d locked=%0d, expected period=%0d high=%0d locked=%0d",
                   period_out, high_out, locked_out, e.period, e.high, e.locked);
        end
      end
    end
    if (watch_to && timeout_out) saw_to = 1'b1;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    signal_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    repeat (50) @(negedge clk);
    check("idle_period", int'(period_out), 0);
    check("idle_high", int'(high_out), 0);
    check("idle_valid", int'(valid_out), 0);
    check("idle_locked", int'(locked_out), 0);
    check("idle_timeout", int'(timeout_out), 0);

    // Divide-by-4 wave.
    wave(2, 2, 1'b0, 0, 0, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b1);
    wave(2, 2, 1'b1, 4, 2, 1'b1);
    wave(2, 2, 1'b1, 4, 2, 1'b1);

    // Switch to divide-by-6.
    wave(3, 3, 1'b1, 4, 2, 1'b1);
    wave(3, 3, 1'b1, 6, 3, 1'b0);
    wave(3, 3, 1'b1, 6, 3, 1'b1);
    wave(3, 3, 1'b1, 6, 3, 1'b1);

    // Back to divide-by-4, then stall.
    wave(2, 2, 1'b1, 6, 3, 1'b1);
    wave(2, 2, 1'b1, 4, 2, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b1);
    repeat (30) @(negedge clk);
    check("stall_timeout", int'(timeout_out), 1);
    check("stall_period", int'(period_out), 4);
    check("stall_high", int'(high_out), 2);
    check("stall_locked", int'(locked_out), 0);

    // Resume: first rise gives no valid and clears lock history.
    wave(2, 2, 1'b0, 0, 0, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b0);
    check("resume_timeout", int'(timeout_out), 0);
    wave(2, 2, 1'b1, 4, 2, 1'b1);

    // Period exactly equal to TIMEOUT: the rise wins.
    watch_to = 1'b1;
    wave(10, 10, 1'b1, 4, 2, 1'b1);
    wave(10, 10, 1'b1, 20, 10, 1'b0);
    wave(10, 10, 1'b1, 20, 10, 1'b1);
    wave(2, 2, 1'b1, 20, 10, 1'b1);
    watch_to = 1'b0;
    check("edge_timeout_seen", int'(saw_to), 0);

    // Reset for one cycle in mid-period with the input high.
    begin
      exp_t e;
      e.period = 4;
      e.high   = 2;
      e.locked = 1'b0;
      exp_q.push_back(e);
    end
    signal_in = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_period", int'(period_out), 0);
    check("rst_high", int'(high_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_locked", int'(locked_out), 0);
    check("rst_timeout", int'(timeout_out), 0);
    repeat (3) @(negedge clk);
    signal_in = 1'b0;
    repeat (3) @(negedge clk);
    wave(2, 2, 1'b0, 0, 0, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b1);

    // Drain and confirm every expected measurement appeared.
    repeat (10) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
